// File: rtl/cpu_types_pkg.sv
// Shared fetch-side types: the fetch FSM encoding, the IF/ID record and the HALT opcode.
package cpu_types_pkg;

  localparam logic [5:0] HaltOpDefault = 6'h3F;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] npc;
  } ifid_t;

  function automatic logic is_halt(input logic [31:0] instr, input logic [5:0] op);
    return instr[31:26] == op;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry IF/ID record buffer that parks a completed fetch while decode is stalled.
module fetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  clear_i,
  input  ifid_t data_i,
  output logic  valid_o,
  output ifid_t data_o
);

  logic  valid_q;
  ifid_t data_q;

  // Clear wins over load: a flush must never leave a stale entry behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem reads, owns IF/ID, absorbs decode stalls in a hold
// buffer, handles flush redirects and parks on HALT.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [5:0]  HALT_OP = HaltOpDefault,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [29:0]      cpc,
  input  logic [29:0]      npc,
  output logic             pcEN,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic             stall,
  input  logic             flush,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [29:0]      ifid_npc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_t     state_q, state_d;
  ifid_t            ifid_q, ifid_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic  halt_hit;
  logic  fetching;
  ifid_t fetched;
  logic  hold_load, hold_clear, hold_valid;
  ifid_t hold_data;

  fetch_hold_buf u_hold_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .data_i  (fetched),
    .valid_o (hold_valid),
    .data_o  (hold_data)
  );

  always_comb begin
    halt_hit = is_halt(imemload, HALT_OP);
    fetching = (state_q == FETCH);
    fetched  = '{instr: imemload, npc: npc};

    imemREN  = fetching;
    imemaddr = {cpc, 2'b00};
    pcEN     = flush | (fetching & ihit & ~halt_hit);

    state_d    = state_q;
    ifid_d     = ifid_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;

    if (flush) begin
      // A same-cycle ihit belongs to the squashed path and is dropped.
      valid_d    = 1'b0;
      hold_clear = 1'b1;
      state_d    = FETCH;
      halted_d   = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ihit) begin
            if (stall) begin
              hold_load = 1'b1;
              state_d   = HOLD;
            end else begin
              ifid_d  = fetched;
              valid_d = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
            end
            if (halt_hit) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d     = hold_data;
            valid_d    = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            hold_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        HALTED: begin
          // A HALT caught under stall still has to drain into decode.
          if (hold_valid && !stall) begin
            ifid_d     = hold_data;
            valid_d    = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            hold_clear = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      ifid_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ifid_q   <= ifid_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ifid_valid = valid_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_npc   = ifid_q.npc;
  assign halted     = halted_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences and random traffic
// against a queue-based reference model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, flush;
  logic [29:0] cpc, npc;
  logic [31:0] imemload;

  logic        pcEN, imemREN, ifid_valid, halted;
  logic [31:0] imemaddr, ifid_instr, fetch_cnt;
  logic [29:0] ifid_npc;

  logic        w_pcen, w_ren, w_valid, w_halted;
  logic [31:0] w_addr, w_instr;
  logic [29:0] w_npc;
  logic [2:0]  w_cnt;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .cpc(cpc), .npc(npc), .pcEN(pcEN), .imemREN(imemREN),
    .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload), .stall(stall), .flush(flush),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  // Narrow counter copy so wrap-around is reachable in a short run.
  fetch_stage #(.CNT_W(3)) dut_w (
    .CLK(CLK), .RST(RST), .cpc(cpc), .npc(npc), .pcEN(w_pcen), .imemREN(w_ren),
    .imemaddr(w_addr), .ihit(ihit), .imemload(imemload), .stall(stall), .flush(flush),
    .ifid_valid(w_valid), .ifid_instr(w_instr), .ifid_npc(w_npc),
    .halted(w_halted), .fetch_cnt(w_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [29:0] npc;
  } rec_t;

  // Reference model: pending queue holds a finished fetch decode has not taken yet.
  rec_t        m_pend[$];
  logic        m_parked;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [29:0] m_npc;
  logic [31:0] m_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input logic h,
                       input logic [31:0] load, input logic [29:0] c, input logic [29:0] n);
    RST = r; flush = f; stall = s; ihit = h; imemload = load; cpc = c; npc = n;
  endtask

  task automatic model_update();
    rec_t r;
    if (RST) begin
      m_pend.delete(); m_parked = 1'b0; m_valid = 1'b0;
      m_instr = '0; m_npc = '0; m_cnt = '0;
    end else if (flush) begin
      m_pend.delete(); m_parked = 1'b0; m_valid = 1'b0;
    end else if (m_pend.size() > 0) begin
      if (!stall) begin
        r = m_pend.pop_front();
        m_instr = r.instr; m_npc = r.npc; m_valid = 1'b1; m_cnt = m_cnt + 1;
      end
    end else if (!m_parked) begin
      if (ihit) begin
        if (stall) m_pend.push_back('{imemload, npc});
        else begin
          m_instr = imemload; m_npc = npc; m_valid = 1'b1; m_cnt = m_cnt + 1;
        end
        if (imemload[31:26] == 6'h3F) m_parked = 1'b1;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    logic ren, pc;
    ren = !m_parked && (m_pend.size() == 0);
    pc  = flush || (ren && ihit && (imemload[31:26] != 6'h3F));
    chk("imemREN",    64'(imemREN),    64'(ren));
    chk("pcEN",       64'(pcEN),       64'(pc));
    chk("pcEN_w",     64'(w_pcen),     64'(pc));
    chk("imemaddr",   64'(imemaddr),   64'({cpc, 2'b00}));
    chk("ifid_valid", 64'(ifid_valid), 64'(m_valid));
    chk("ifid_instr", 64'(ifid_instr), 64'(m_instr));
    chk("ifid_npc",   64'(ifid_npc),   64'(m_npc));
    chk("halted",     64'(halted),     64'(m_parked));
    chk("fetch_cnt",  64'(fetch_cnt),  64'(m_cnt));
    chk("fetch_cnt_w", 64'(w_cnt),     64'(m_cnt[2:0]));
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge CLK);
    model_check();
    tick();
  endtask

  typedef struct {
    logic        flush, stall, ihit;
    logic [31:0] load;
    logic [29:0] npc;
    logic        pcen, ren, valid;
    logic [31:0] instr;
    logic [29:0] inpc;
    logic        halted;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    //           flush stall ihit load           npc   pcEN ren valid instr          inpc halt cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h2001_0005, 30'd1, 1'b1, 1'b1, 1'b1, 32'h2001_0005, 30'd1, 1'b0, 1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         30'd1, 1'b0, 1'b1, 1'b0, 32'h2001_0005, 30'd1, 1'b0, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         30'd1, 1'b0, 1'b1, 1'b0, 32'h2001_0005, 30'd1, 1'b0, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         30'd1, 1'b0, 1'b1, 1'b0, 32'h2001_0005, 30'd1, 1'b0, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_1111, 30'd2, 1'b1, 1'b1, 1'b1, 32'h0000_1111, 30'd2, 1'b0, 2};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h8C22_0004, 30'd3, 1'b1, 1'b1, 1'b1, 32'h0000_1111, 30'd2, 1'b0, 2};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h0BAD_0001, 30'd9, 1'b0, 1'b0, 1'b1, 32'h0000_1111, 30'd2, 1'b0, 2};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h0BAD_0002, 30'd9, 1'b0, 1'b0, 1'b1, 32'h0000_1111, 30'd2, 1'b0, 2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0BAD_0003, 30'd9, 1'b0, 1'b0, 1'b1, 32'h8C22_0004, 30'd3, 1'b0, 3};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 30'd4, 1'b1, 1'b1, 1'b0, 32'h8C22_0004, 30'd3, 1'b0, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 30'd5, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 30'd5, 1'b1, 4};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 30'd6, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 30'd5, 1'b1, 4};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 30'd6, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 30'd5, 1'b0, 4};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 30'd6, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 30'd5, 1'b0, 4};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 30'd0, 30'd0);
    tick();
    tick();
    chk("rst_valid",  64'(ifid_valid), 64'(0));
    chk("rst_instr",  64'(ifid_instr), 64'(0));
    chk("rst_npc",    64'(ifid_npc),   64'(0));
    chk("rst_halted", 64'(halted),     64'(0));
    chk("rst_cnt",    64'(fetch_cnt),  64'(0));

    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tbl[i].flush, tbl[i].stall, tbl[i].ihit, tbl[i].load, 30'(i * 3),
            tbl[i].npc);
      @(negedge CLK);
      model_check();
      chk($sformatf("tbl%0d_pcEN", i),    64'(pcEN),    64'(tbl[i].pcen));
      chk($sformatf("tbl%0d_imemREN", i), 64'(imemREN), 64'(tbl[i].ren));
      tick();
      chk($sformatf("tbl%0d_valid", i),  64'(ifid_valid), 64'(tbl[i].valid));
      chk($sformatf("tbl%0d_instr", i),  64'(ifid_instr), 64'(tbl[i].instr));
      chk($sformatf("tbl%0d_npc", i),    64'(ifid_npc),   64'(tbl[i].inpc));
      chk($sformatf("tbl%0d_halted", i), 64'(halted),     64'(tbl[i].halted));
      chk($sformatf("tbl%0d_cnt", i),    64'(fetch_cnt),  64'(tbl[i].cnt));
    end

    // Flush while holding: the held instruction must never reach IF/ID.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA_0001, 30'd20, 30'd21); cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 30'd21, 30'd22);         cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2222, 30'd21, 30'd22); cycle();
    chk("flushhold_valid", 64'(ifid_valid), 64'(0));
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 30'd40, 30'd41);
      cycle();
      chk("flushhold_gone", 64'(ifid_instr == 32'hAAAA_0001), 64'(0));
      chk("flushhold_bubble", 64'(ifid_valid), 64'(0));
    end

    // Direct HALT: parked for 10 cycles whatever arrives, then flush releases.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 30'd50, 30'd51); cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, $urandom, 30'd52, 30'd53);
      @(negedge CLK);
      model_check();
      chk("halt_ren",  64'(imemREN), 64'(0));
      chk("halt_pcen", 64'(pcEN),    64'(0));
      tick();
      chk("halt_halted", 64'(halted),     64'(1));
      chk("halt_valid",  64'(ifid_valid), 64'(1));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 30'd60, 30'd61); cycle();
    chk("halt_release", 64'(halted), 64'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 30'd60, 30'd61);
    @(negedge CLK);
    chk("halt_refetch", 64'(imemREN), 64'(1));
    tick();

    // HALT caught under stall still drains into IF/ID.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFC00_0000, 30'd70, 30'd71); cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 30'd72, 30'd73);         cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 30'd72, 30'd73);         cycle();
    chk("haltheld_instr", 64'(ifid_instr), 64'(32'hFC00_0000));
    chk("haltheld_npc",   64'(ifid_npc),   64'(30'd71));
    chk("haltheld_halt",  64'(halted),     64'(1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 30'd72, 30'd73); cycle();

    // Reset while holding under a pending stall.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_2222, 30'd80, 30'd81); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h3333_4444, 30'd82, 30'd83); cycle();
    chk("rsthold_valid", 64'(ifid_valid), 64'(0));
    chk("rsthold_instr", 64'(ifid_instr), 64'(0));
    chk("rsthold_npc",   64'(ifid_npc),   64'(0));
    chk("rsthold_cnt",   64'(fetch_cnt),  64'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 30'd84, 30'd85);
    @(negedge CLK);
    chk("rsthold_ren", 64'(imemREN), 64'(1));
    tick();

    // Eight accepts wrap the 3-bit counter back to zero.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0000 + 32'(i), 30'(90 + i), 30'(91 + i));
      cycle();
    end
    chk("wrap_narrow", 64'(w_cnt),     64'(0));
    chk("wrap_wide",   64'(fetch_cnt), 64'(8));

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ld;
      ld = $urandom;
      if ($urandom_range(0, 9) == 0) ld[31:26] = 6'h3F;
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ld,
            30'($urandom), 30'($urandom));
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 30'd0, 30'd1);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of the PC block. Each cycle it issues an instruction-memory read at the current PC and owns the IF/ID pipeline register. It drives the PC-advance enable back to the PC block and absorbs decode stalls in a one-entry hold buffer, so a completed fetch is never re-requested. It also handles pipeline flush and latches HALT.

Parameters:
HALT_OP, 6'h3F, opcode field [31:26] that parks fetch in HALTED
CNT_W, 32, width of the retired-fetch counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
cpc  in  30  current PC word address [31:2], from PC block
npc  in  30  PC+4 word address [31:2], from PC block
pcEN  out  1  PC load enable, to PC block
imemREN  out  1  instruction read request
imemaddr  out  32  {cpc,2'b00}
ihit  in  1  read complete this cycle; imemload valid
imemload  in  32  fetched instruction
stall  in  1  decode cannot accept IF/ID this cycle (hazard unit)
flush  in  1  redirect resolved downstream; squash fetch-side state
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instr  out  32  IF/ID instruction
ifid_npc  out  30  IF/ID PC+4, consumed as pipe_npc downstream
halted  out  1  fetch parked on HALT
fetch_cnt  out  CNT_W  instructions written into IF/ID since reset

Behaviour:
- Reset, applied synchronously at the edge: state=FETCH, ifid_valid=0, ifid_instr=0, ifid_npc=0, hold buffer empty, fetch_cnt=0, halted=0. A reset asserted in any state, including mid-miss or HALTED, wins over every other input.
- Combinational outputs:
  - imemREN = (state==FETCH).
  - imemaddr = {cpc,2'b00}.
  - pcEN = flush | (state==FETCH & ihit & !halt_hit), where halt_hit = (imemload[31:26]==HALT_OP).
- Priority each cycle: RST > flush > normal operation.
- flush: ifid_valid<=0, hold buffer cleared, state<=FETCH, halted<=0. pcEN=1 so the PC loads the redirect target. Any ihit arriving the same cycle is discarded and fetch_cnt does not increment.
- FETCH, ihit=0:
  - stall=1: IF/ID holds.
  - stall=0: ifid_valid<=0 (bubble).
- FETCH, ihit=1, stall=0: IF/ID<={imemload,npc}, ifid_valid<=1, fetch_cnt+=1.
- FETCH, ihit=1, stall=1: hold buffer<={imemload,npc}; state<=HOLD. IF/ID is unchanged. The PC still advances.
- HOLD: imemREN=0, pcEN=0.
  - stall=1: remain in HOLD.
  - stall=0: IF/ID<=hold buffer, ifid_valid<=1, fetch_cnt+=1, state<=FETCH. No fetch is issued that cycle; the next fetch starts the following cycle.
- HALT detection: applies to any instruction accepted from imemload (direct or via hold). If halt_hit, the instruction is still written into IF/ID/hold, pcEN=0, state<=HALTED, halted<=1.
- HALTED:
  - imemREN=0, pcEN=0, IF/ID holds, so the pipeline drains the HALT.
  - Exit only on flush (HALT was speculative) or RST.
  - If the HALT is in the hold buffer, the stall release still transfers it into IF/ID.
- fetch_cnt wraps modulo 2^CNT_W with no saturation.
- Invariant: the hold buffer is non-empty only in HOLD or HALTED.

Decomposition:
- fetch_state_t enum {FETCH, HOLD, HALTED} and the ifid_t packed struct {instr, npc} belong in cpu_types_pkg.
- HALT_OP default belongs as a named constant in the same package.
- One sub-module is natural: fetch_hold_buf, the one-entry ifid_t register with load/clear/valid. Everything else is inline.

Test Plan:
- Reset then hits: cpc=0, npc=1, ihit=1, imemload=32'h2001_0005, stall=0 -> next cycle ifid_valid=1, ifid_instr=32'h2001_0005, ifid_npc=1, pcEN was 1, fetch_cnt=1.
- Miss bubble: ihit=0 for 3 cycles, stall=0 -> imemREN=1, pcEN=0, ifid_valid=0 each cycle; fetch_cnt unchanged.
- Stall absorb: ihit=1 with instr 32'h8C22_0004, stall=1 -> state HOLD, pcEN=1 once then 0, imemREN=0. IF/ID keeps its old contents for 2 stalled cycles. After stall drops, IF/ID=32'h8C22_0004 and fetch_cnt increments exactly once.
- Flush races hit: flush=1 and ihit=1 in the same cycle -> ifid_valid=0, pcEN=1, fetch_cnt unchanged. Repeat from HOLD: hold buffer discarded, the held instruction never appears.
- Halt: imemload=32'hFFFF_FFFF accepted -> ifid_valid=1, halted=1, pcEN=0, imemREN=0 for 10 cycles. flush -> halted=0, FETCH, imemREN=1 next cycle.
- Reset mid-operation: RST=1 while in HOLD with a pending stall -> all outputs at reset values the next cycle. fetch_cnt at 32'hFFFF_FFFF plus one accept -> wraps to 0.
